machine_csr_file: RTL

Parametrised machine-mode CSR file for the single-hart RV32 core; successor to the fixed CSR block. Adds atomic read-modify-write ops, trap entry and `mret` sequencing, interrupt arbitration, vectored `mtvec`, and a configurable bank of event-driven hardware performance counters with `mcountinhibit`. Sits beside the register file; the core's decode and trap logic drive it.

---
 rtl/csr_pkg.sv | 47 ++++
 rtl/csr_counter.sv | 24 ++
 rtl/machine_csr_file.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encoding, interrupt cause codes and fixed values
// for the machine-mode CSR file.
package csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;
    localparam logic [11:0] ADDR_MCONFIGPTR    = 12'hF15;
    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MENVCFG       = 12'h30A;
    localparam logic [11:0] ADDR_MSTATUSH      = 12'h310;
    localparam logic [11:0] ADDR_MENVCFGH      = 12'h31A;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] ADDR_MIP           = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;

    // Upper address bits of the 32-entry hpm event / counter windows
    localparam logic [6:0] PAGE_MHPMEVENT    = 7'b0011001;
    localparam logic [6:0] PAGE_MHPMCOUNTER  = 7'b1011000;
    localparam logic [6:0] PAGE_MHPMCOUNTERH = 7'b1011100;

    localparam logic [30:0] CAUSE_MSI = 31'd3;
    localparam logic [30:0] CAUSE_MTI = 31'd7;
    localparam logic [30:0] CAUSE_MEI = 31'd11;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

endpackage

// File: rtl/csr_counter.sv
// 64-bit wrapping event counter; a write to either half suppresses that
// cycle's increment for the whole counter.
module csr_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        increment,
    input  logic        write_low,
    input  logic        write_high,
    input  logic [31:0] write_data,
    output logic [63:0] value
);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (write_low || write_high) begin
            if (write_low)  value[31:0]  <= write_data;
            if (write_high) value[63:32] <= write_data;
        end else if (increment) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/machine_csr_file.sv
// Machine-mode CSR file: RW/RS/RC access, trap/mret sequencing, interrupt
// arbitration, vectored mtvec and a bank of hardware performance counters.
module machine_csr_file
    import csr_pkg::*;
#(
    parameter int unsigned HPM_COUNTERS = 4,
    parameter int unsigned EVENTS       = 8,
    parameter bit          VECTORED     = 1'b1,
    parameter logic [31:0] HART_ID      = 32'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       address,
    input  logic [1:0]        op,
    input  logic [31:0]       write_value,
    output logic [31:0]       read_value,
    output logic              illegal,
    input  logic              trap,
    input  logic              trap_interrupt,
    input  logic [30:0]       trap_cause,
    input  logic [31:0]       trap_pc,
    input  logic [31:0]       trap_value,
    input  logic              mret,
    input  logic              retire,
    input  logic [EVENTS-1:0] events,
    input  logic              external_irq,
    input  logic              timer_irq,
    input  logic              software_irq,
    output logic              interrupt_request,
    output logic [30:0]       interrupt_cause,
    output logic [31:0]       trap_vector,
    output logic [31:0]       mepc_out
);

    localparam int unsigned EW = (EVENTS > 1) ? $clog2(EVENTS + 1) : 1;
    // Inhibit bits exist for mcycle, minstret and each implemented hpm counter
    localparam logic [31:0] INHIBIT_MASK =
        (((32'd1 << HPM_COUNTERS) - 32'd1) << 3) | 32'd5;

    csr_op_e     op_e;
    logic        status_mie, status_mpie;
    logic [29:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic [31:0] mie_reg, mscratch, mepc, mcause, mtval, mcountinhibit;
    logic [31:0] mip;
    logic [63:0] mcycle, minstret;
    logic [31:0][63:0] hpm_value;
    logic [31:0][31:0] hpm_event;
    logic [31:0] rdata, wdata;
    logic [4:0]  idx;
    logic        valid, writes, csr_we;
    logic [31:0] pending;

    assign op_e = csr_op_e'(op);
    assign idx  = address[4:0];
    assign mip  = {20'd0, external_irq, 3'd0, timer_irq, 3'd0, software_irq, 3'd0};

    always_comb begin
        rdata = '0;
        valid = 1'b1;
        case (address)
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID, ADDR_MCONFIGPTR,
            ADDR_MSTATUSH, ADDR_MENVCFG, ADDR_MENVCFGH: rdata = '0;
            ADDR_MHARTID:       rdata = HART_ID;
            ADDR_MISA:          rdata = MISA_VALUE;
            ADDR_MSTATUS:       rdata = {19'd0, 2'b11, 3'd0, status_mpie, 3'd0, status_mie, 3'd0};
            ADDR_MIE:           rdata = mie_reg;
            ADDR_MTVEC:         rdata = {mtvec_base, mtvec_mode};
            ADDR_MCOUNTINHIBIT: rdata = mcountinhibit;
            ADDR_MSCRATCH:      rdata = mscratch;
            ADDR_MEPC:          rdata = mepc;
            ADDR_MCAUSE:        rdata = mcause;
            ADDR_MTVAL:         rdata = mtval;
            ADDR_MIP:           rdata = mip;
            ADDR_MCYCLE:        rdata = mcycle[31:0];
            ADDR_MCYCLEH:       rdata = mcycle[63:32];
            ADDR_MINSTRET:      rdata = minstret[31:0];
            ADDR_MINSTRETH:     rdata = minstret[63:32];
            default: begin
                if (address[11:5] == PAGE_MHPMEVENT && idx >= 5'd3)
                    rdata = hpm_event[idx];
                else if (address[11:5] == PAGE_MHPMCOUNTER && idx >= 5'd3)
                    rdata = hpm_value[idx][31:0];
                else if (address[11:5] == PAGE_MHPMCOUNTERH && idx >= 5'd3)
                    rdata = hpm_value[idx][63:32];
                else
                    valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (op_e)
            OP_RS:   wdata = rdata | write_value;
            OP_RC:   wdata = rdata & ~write_value;
            default: wdata = write_value;
        endcase
    end

    // RS/RC with a zero operand is a pure read and may touch read-only space
    assign writes     = (op_e == OP_RW) || (write_value != 32'd0);
    assign illegal    = (op_e != OP_NONE) &&
                        (!valid || (writes && address[11:10] == 2'b11));
    assign read_value = rdata;
    assign csr_we     = (op_e != OP_NONE) && !illegal && writes && !trap && !mret;

    always_ff @(posedge clock) begin
        if (reset) begin
            status_mie    <= 1'b0;
            status_mpie   <= 1'b0;
            mtvec_base    <= '0;
            mtvec_mode    <= '0;
            mie_reg       <= '0;
            mscratch      <= '0;
            mepc          <= '0;
            mcause        <= '0;
            mtval         <= '0;
            mcountinhibit <= '0;
        end else if (trap) begin
            mepc        <= {trap_pc[31:2], 2'b00};
            mcause      <= {trap_interrupt, trap_cause};
            mtval       <= trap_value;
            status_mpie <= status_mie;
            status_mie  <= 1'b0;
        end else if (mret) begin
            status_mie  <= status_mpie;
            status_mpie <= 1'b1;
        end else if (csr_we) begin
            case (address)
                ADDR_MSTATUS: begin
                    status_mie  <= wdata[3];
                    status_mpie <= wdata[7];
                end
                ADDR_MTVEC: begin
                    mtvec_base <= wdata[31:2];
                    if (wdata[1:0] == 2'd0 || (wdata[1:0] == 2'd1 && VECTORED))
                        mtvec_mode <= wdata[1:0];
                end
                ADDR_MIE:           mie_reg       <= wdata & MIE_MASK;
                ADDR_MSCRATCH:      mscratch      <= wdata;
                ADDR_MEPC:          mepc          <= {wdata[31:2], 2'b00};
                ADDR_MCAUSE:        mcause        <= wdata;
                ADDR_MTVAL:         mtval         <= wdata;
                ADDR_MCOUNTINHIBIT: mcountinhibit <= wdata & INHIBIT_MASK;
                default: ;
            endcase
        end
    end

    csr_counter u_mcycle (
        .clock      (clock),
        .reset      (reset),
        .increment  (!mcountinhibit[0]),
        .write_low  (csr_we && address == ADDR_MCYCLE),
        .write_high (csr_we && address == ADDR_MCYCLEH),
        .write_data (wdata),
        .value      (mcycle)
    );

    csr_counter u_minstret (
        .clock      (clock),
        .reset      (reset),
        .increment  (retire && !mcountinhibit[2]),
        .write_low  (csr_we && address == ADDR_MINSTRET),
        .write_high (csr_we && address == ADDR_MINSTRETH),
        .write_data (wdata),
        .value      (minstret)
    );

    for (genvar g = 0; g < 32; g++) begin : g_hpm
        if (g >= 3 && g < 3 + HPM_COUNTERS) begin : g_impl
            localparam logic [11:0] EVT_ADDR = {PAGE_MHPMEVENT, 5'(g)};
            localparam logic [11:0] LO_ADDR  = {PAGE_MHPMCOUNTER, 5'(g)};
            localparam logic [11:0] HI_ADDR  = {PAGE_MHPMCOUNTERH, 5'(g)};
            logic [31:0]     sel;
            logic [EVENTS:0] ev_ext;
            logic            hit;

            always_ff @(posedge clock) begin
                if (reset)
                    sel <= '0;
                else if (csr_we && address == EVT_ADDR)
                    sel <= wdata;
            end

            // Slot 0 of ev_ext is tied low so selector 0 never counts
            assign ev_ext = {events, 1'b0};
            assign hit    = (sel <= 32'(EVENTS)) && ev_ext[sel[EW-1:0]];

            csr_counter u_cnt (
                .clock      (clock),
                .reset      (reset),
                .increment  (hit && !mcountinhibit[g]),
                .write_low  (csr_we && address == LO_ADDR),
                .write_high (csr_we && address == HI_ADDR),
                .write_data (wdata),
                .value      (hpm_value[g])
            );
            assign hpm_event[g] = sel;
        end else begin : g_none
            assign hpm_value[g] = '0;
            assign hpm_event[g] = '0;
        end
    end

    assign pending           = mip & mie_reg;
    assign interrupt_request = status_mie && (pending != 32'd0);

    always_comb begin
        interrupt_cause = '0;
        if (status_mie) begin
            if (pending[11])     interrupt_cause = CAUSE_MEI;
            else if (pending[3]) interrupt_cause = CAUSE_MSI;
            else if (pending[7]) interrupt_cause = CAUSE_MTI;
        end
    end

    assign trap_vector = {mtvec_base, 2'b00} +
                         ((mtvec_mode == 2'd1 && trap_interrupt) ? 32'({trap_cause, 2'b00}) : 32'd0);
    assign mepc_out    = mepc;

endmodule
